// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter and its matching receiver.
// Contents: tx_state_t FSM encoding, LINE_IDLE (mark level), START_LVL (start-bit level).
// No ports; imported by serial_frame_tx and bit_tick_gen.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps; tick_o marks the last
// cycle of each serial bit. Ports: clk, rst (sync, active-high), clr_i (sync clear), en_i (count
// enable), cnt_o (current count), tick_o (last cycle of bit, combinational from the count register).
module bit_tick_gen import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = 4,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tick_o
);

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // With CLKS_PER_BIT=1 the count stays at 0 and every enabled cycle is a tick.
  assign tick_o = en_i && (cnt_q == LAST_CNT);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, optional even parity, stop bit,
// each held CLKS_PER_BIT clocks. Ports: clk, rst (sync, active-high), in_data/in_valid/in_ready
// (word handshake, ready only in IDLE), tx_so (serial line, idles high), busy, frame_done (pulse).
module serial_frame_tx import serial_pkg::*; #(
  parameter int DATA_W       = 5,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_so,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  // frame_done is registered, so it is set on the edge that starts the last STOP cycle.
  // When a bit lasts a single clock that edge is the one entering STOP.
  localparam logic          DONE_ON_ENTRY = (CLKS_PER_BIT == 1);
  localparam logic [CW-1:0] PRE_LAST      = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [BW-1:0]     bit_cnt_q;
  logic              parity_q;
  logic              tx_so_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              frame_done_q;

  logic              tick;
  logic [CW-1:0]     tick_cnt;

  // Counter is held at zero in IDLE so the start bit always gets a full bit period.
  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q != IDLE),
    .cnt_o  (tick_cnt),
    .tick_o (tick)
  );

  assign shift_d = shift_q >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      tx_so_q      <= LINE_IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_done_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            shift_q    <= in_data;
            parity_q   <= ^in_data;
            bit_cnt_q  <= '0;
            state_q    <= START;
            tx_so_q    <= START_LVL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            state_q   <= DATA;
            tx_so_q   <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_so_q <= parity_q;
              end else begin
                state_q      <= STOP;
                tx_so_q      <= LINE_IDLE;
                frame_done_q <= DONE_ON_ENTRY;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              shift_q   <= shift_d;
              tx_so_q   <= shift_d[0];
            end
          end
        end

        PARITY: begin
          if (tick) begin
            state_q      <= STOP;
            tx_so_q      <= LINE_IDLE;
            frame_done_q <= DONE_ON_ENTRY;
          end
        end

        STOP: begin
          if (tick) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
          end else begin
            frame_done_q <= (tick_cnt == PRE_LAST);
          end
        end

        default: begin
          state_q    <= IDLE;
          tx_so_q    <= LINE_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign tx_so      = tx_so_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: default build (5 bits, 4 clocks/bit, parity) and a fast build
// (5 bits, 1 clock/bit, no parity) share one stimulus stream. A frame-level model predicts
// every output cycle; a separate monitor pops the predictions and compares.
module tb_serial_frame_tx;

  localparam int CPB0 = 4;
  localparam int PEN0 = 1;
  localparam int CPB1 = 1;
  localparam int PEN1 = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_data = 5'b11111;
  logic       in_valid = 1'b1;

  logic rdy0, tx0, bsy0, dn0;
  logic rdy1, tx1, bsy1, dn1;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(CPB0), .PARITY_EN(PEN0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .tx_so(tx0), .busy(bsy0), .frame_done(dn0)
  );

  serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(CPB1), .PARITY_EN(PEN1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .tx_so(tx1), .busy(bsy1), .frame_done(dn1)
  );

  typedef struct packed {
    logic tx;
    logic rdy;
    logic bsy;
    logic done;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_exp[2] = '{0, 0};
  int frames_seen[2] = '{0, 0};

  // Line level k cycles into a frame, straight from the frame layout:
  // bit 0 start, bits 1..5 data LSB-first, then even parity if enabled, then stop.
  function automatic logic exp_bit(logic [4:0] d, int k, int cpb, int pen);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= 5) return d[b-1];
    if (pen != 0 && b == 6) return ^d;
    return 1'b1;
  endfunction

  function automatic int frame_len(int cpb, int pen);
    return (5 + pen + 2) * cpb;
  endfunction

  task automatic cmp(int inst, string name, logic got, logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %b, expected %b", name, inst, cyc, got, want);
    end
  endtask

  task automatic cmp_all(int inst, exp_t e, logic tx, logic rdy, logic bsy, logic dn);
    cmp(inst, "tx_so", tx, e.tx);
    cmp(inst, "in_ready", rdy, e.rdy);
    cmp(inst, "busy", bsy, e.bsy);
    cmp(inst, "frame_done", dn, e.done);
  endtask

  // Reference model: position within the current frame (-1 = idle and ready).
  int         idx[2] = '{-1, -1};
  logic [4:0] dat[2];
  bit         started = 1'b0;

  initial begin
    exp_t e;
    int   cpb;
    int   pen;
    int   len;
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        cpb = (i == 0) ? CPB0 : CPB1;
        pen = (i == 0) ? PEN0 : PEN1;
        len = frame_len(cpb, pen);
        if (rst) begin
          started = 1'b1;
          idx[i]  = -1;
        end else if (started) begin
          if (idx[i] >= 0) begin
            // After the last stop cycle there is always one idle cycle.
            idx[i] = (idx[i] + 1 < len) ? idx[i] + 1 : -1;
          end else if (in_valid) begin
            dat[i] = in_data;
            idx[i] = 0;
          end
        end
        if (started) begin
          if (idx[i] < 0) begin
            e = '{tx: 1'b1, rdy: 1'b1, bsy: 1'b0, done: 1'b0};
          end else begin
            e = '{tx: exp_bit(dat[i], idx[i], cpb, pen), rdy: 1'b0, bsy: 1'b1,
                  done: (idx[i] == len - 1)};
          end
          if (e.done) frames_exp[i]++;
          if (i == 0) exp0.push_back(e);
          else        exp1.push_back(e);
        end
      end
    end
  end

  // Monitor: compare every presented output cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        cmp_all(0, e, tx0, rdy0, bsy0, dn0);
        if (dn0 === 1'b1) frames_seen[0]++;
      end
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        cmp_all(1, e, tx1, rdy1, bsy1, dn1);
        if (dn1 === 1'b1) frames_seen[1]++;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [4:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held with in_valid asserted: nothing may start.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'b11111;
    step(3);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(2);

    // Single frame.
    send(5'b10110);
    step(40);

    // Word offered during DATA is ignored.
    send(5'b00001);
    step(10);
    in_valid = 1'b1;
    in_data  = 5'b11111;
    step(8);
    in_valid = 1'b0;
    step(40);

    // Reset in the second data bit, then a clean all-zero frame.
    send(5'b10101);
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    send(5'b00000);
    step(40);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_data  = 5'b11111;
    step(1);
    in_data  = 5'b01010;
    step(40);
    in_valid = 1'b0;
    step(40);

    // Short frame (exercised on the fast build too).
    send(5'b00011);
    step(40);

    // Randomised traffic with occasional resets.
    repeat (40) begin
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      in_valid = 1'b1;
      repeat ($urandom_range(1, 40)) begin
        in_data = 5'($urandom);
        if ($urandom_range(0, 5) == 0) rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      in_valid = 1'b0;
      step($urandom_range(0, 20));
    end

    step(60);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (frames_seen[i] != frames_exp[i]) begin
        errors++;
        $display("FAIL frame_count inst%0d: got %0d, expected %0d", i, frames_seen[i], frames_exp[i]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
